dsp_idebn_bank: RTL and testbench

- Parametrised multi-channel input debouncer and edge detector; successor to the 2-sample single-bit debouncer.
- Serves external flag and interrupt pins entering the DSP core.
- Per channel: configurable synchroniser depth, programmable stability count clocked by a shared sample strobe, polarity select, one-cycle rise/fall pulses.
- Feeds the interrupt controller and the status registers.

---
 rtl/dsp_idebn_pkg.sv | 28 ++
 rtl/dsp_idebn_ch.sv | 82 ++++++++
 rtl/dsp_idebn_bank.sv | 67 ++++++
 tb/tb_dsp_idebn_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_idebn_pkg.sv
// Shared constants and helpers for the dsp_idebn input debouncer bank.
// Holds the configuration limits, the counter-width function and the
// parameter sanity check evaluated at elaboration by dsp_idebn_bank.
package dsp_idebn_pkg;

    localparam int DEB_CNT_MAX = 15;
    localparam int SYNC_MIN    = 2;
    localparam int NCH_MAX     = 16;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic bit params_ok(input int nch, input int sync_stages, input int deb_cnt);
        return (nch >= 1) && (nch <= NCH_MAX) &&
               (sync_stages >= SYNC_MIN) &&
               (deb_cnt >= 1) && (deb_cnt <= DEB_CNT_MAX);
    endfunction

endpackage

// File: rtl/dsp_idebn_ch.sv
// Single-channel debouncer: synchroniser chain, strobe-clocked stability
// counter, debounced level and one-cycle rise/fall pulses.
// Ports: CLK/RST, smp_en strobe, raw pin + pol invert in; lvl, rise, fall,
// upd (combinational "update fires this edge") out. With IDEB_STICKY_EN
// defined, stk_clr in and sticky out add a latched change flag.
module dsp_idebn_ch
    import dsp_idebn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic smp_en,
    input  logic raw,
    input  logic pol,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic upd
`ifdef IDEB_STICKY_EN
    ,
    input  logic stk_clr,
    output logic sticky
`endif
);

    localparam int            CW   = clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    logic [CW-1:0]          cnt;

    // Polarity is applied before synchronising so a POL change is debounced
    // exactly like a pin change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw ^ pol};
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];
    assign upd = smp_en && (syn != lvl) && (cnt == LAST);

    // Any agreeing sample restarts the count, which gives glitch rejection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= upd & syn;
            fall <= upd & ~syn;
            if (smp_en) begin
                if ((syn == lvl) || upd) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (upd) begin
                    lvl <= syn;
                end
            end
        end
    end

`ifdef IDEB_STICKY_EN
    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sticky <= 1'b0;
        end else begin
            sticky <= rise | fall | (sticky & ~stk_clr);
        end
    end
`endif

endmodule

// File: rtl/dsp_idebn_bank.sv
// NCH-channel input debouncer / edge detector bank for external flag pins.
// Ports: CLK, RST (async active-high), SMP_EN strobe, IN/POL per channel in;
// OUT, RISE, FALL per channel and CHG (any edge) out. Build macro
// IDEB_STICKY_EN adds STK_CLR (write-1-to-clear) in and STICKY out.
module dsp_idebn_bank
    import dsp_idebn_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           SMP_EN,
    input  logic [NCH-1:0] IN,
    input  logic [NCH-1:0] POL,
    output logic [NCH-1:0] OUT,
    output logic [NCH-1:0] RISE,
    output logic [NCH-1:0] FALL,
    output logic           CHG
`ifdef IDEB_STICKY_EN
    ,
    input  logic [NCH-1:0] STK_CLR,
    output logic [NCH-1:0] STICKY
`endif
);

    generate
        if (!params_ok(NCH, SYNC_STAGES, DEB_CNT)) begin : g_param_err
            $error("dsp_idebn_bank: NCH, SYNC_STAGES or DEB_CNT out of range");
        end
    endgenerate

    logic [NCH-1:0] upd;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        dsp_idebn_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT     (DEB_CNT)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .smp_en  (SMP_EN),
            .raw     (IN[i]),
            .pol     (POL[i]),
            .lvl     (OUT[i]),
            .rise    (RISE[i]),
            .fall    (FALL[i]),
            .upd     (upd[i])
`ifdef IDEB_STICKY_EN
            ,
            .stk_clr (STK_CLR[i]),
            .sticky  (STICKY[i])
`endif
        );
    end

    // Registered from the same update terms as RISE/FALL so it aligns with them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CHG <= 1'b0;
        end else begin
            CHG <= |upd;
        end
    end

endmodule

// File: tb/tb_dsp_idebn_bank.sv
module tb_dsp_idebn_bank;

    localparam int NCH   = 8;
    localparam int SYNC  = 2;
    localparam int DEB_A = 3;
    localparam int DEB_B = 1;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           SMP_EN = 1'b0;
    logic [NCH-1:0] IN = '0;
    logic [NCH-1:0] POL = '0;
    logic [NCH-1:0] out0, rise0, fall0, out1, rise1, fall1;
    logic           chg0, chg1;
`ifdef IDEB_STICKY_EN
    logic [NCH-1:0] STK_CLR = '0;
    logic [NCH-1:0] sticky0, sticky1;
`endif

    int checks = 0;
    int failures = 0;
    int fall1_cnt = 0;

    always #5 CLK = ~CLK;

    dsp_idebn_bank #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CNT(DEB_A)) u_dut_a (
        .CLK(CLK), .RST(RST), .SMP_EN(SMP_EN), .IN(IN), .POL(POL),
        .OUT(out0), .RISE(rise0), .FALL(fall0), .CHG(chg0)
`ifdef IDEB_STICKY_EN
        , .STK_CLR(STK_CLR), .STICKY(sticky0)
`endif
    );

    dsp_idebn_bank #(.NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CNT(DEB_B)) u_dut_b (
        .CLK(CLK), .RST(RST), .SMP_EN(SMP_EN), .IN(IN), .POL(POL),
        .OUT(out1), .RISE(rise1), .FALL(fall1), .CHG(chg1)
`ifdef IDEB_STICKY_EN
        , .STK_CLR(STK_CLR), .STICKY(sticky1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the pin value seen by the debouncer is the
    // (IN^POL) vector from SYNC edges ago; a channel flips after DEB
    // consecutive strobes that disagree with its level.
    logic [NCH-1:0] hist [$];
    logic [NCH-1:0] m_out [2];
    logic [NCH-1:0] m_rise [2];
    logic [NCH-1:0] m_fall [2];
    logic           m_chg [2];
    int             m_run [2][NCH];
`ifdef IDEB_STICKY_EN
    logic [NCH-1:0] m_sticky [2];
`endif

    always @(posedge CLK) begin
        logic [NCH-1:0] seen;
        int deb;
        if (RST) begin
            hist = {};
            for (int j = 0; j < SYNC; j++) hist.push_front('0);
            for (int k = 0; k < 2; k++) begin
                m_out[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0;
`ifdef IDEB_STICKY_EN
                m_sticky[k] = '0;
`endif
                for (int c = 0; c < NCH; c++) m_run[k][c] = 0;
            end
        end else begin
            hist.push_front(IN ^ POL);
            seen = hist[SYNC];
            void'(hist.pop_back());
            for (int k = 0; k < 2; k++) begin
                deb = (k == 0) ? DEB_A : DEB_B;
`ifdef IDEB_STICKY_EN
                m_sticky[k] = m_rise[k] | m_fall[k] | (m_sticky[k] & ~STK_CLR);
`endif
                m_rise[k] = '0;
                m_fall[k] = '0;
                if (SMP_EN) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (seen[c] == m_out[k][c]) begin
                            m_run[k][c] = 0;
                        end else if (m_run[k][c] + 1 == deb) begin
                            m_out[k][c] = seen[c];
                            m_run[k][c] = 0;
                            if (seen[c]) m_rise[k][c] = 1'b1;
                            else         m_fall[k][c] = 1'b1;
                        end else begin
                            m_run[k][c] = m_run[k][c] + 1;
                        end
                    end
                end
                m_chg[k] = |(m_rise[k] | m_fall[k]);
            end
        end
    end

    always @(negedge CLK) begin
        if (fall0[1]) fall1_cnt++;
        if (!RST) begin
            chk("m_out_a",  32'(out0),  32'(m_out[0]));
            chk("m_rise_a", 32'(rise0), 32'(m_rise[0]));
            chk("m_fall_a", 32'(fall0), 32'(m_fall[0]));
            chk("m_chg_a",  32'(chg0),  32'(m_chg[0]));
            chk("m_out_b",  32'(out1),  32'(m_out[1]));
            chk("m_rise_b", 32'(rise1), 32'(m_rise[1]));
            chk("m_fall_b", 32'(fall1), 32'(m_fall[1]));
            chk("m_chg_b",  32'(chg1),  32'(m_chg[1]));
`ifdef IDEB_STICKY_EN
            chk("m_sticky_a", 32'(sticky0), 32'(m_sticky[0]));
            chk("m_sticky_b", 32'(sticky1), 32'(m_sticky[1]));
`endif
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic strobe();
        SMP_EN = 1'b1;
        tick(1);
        SMP_EN = 1'b0;
    endtask

    initial begin
        int f0;
        logic nv;
        POL = 8'h20;
        tick(2);
        chk("rst_out",  32'(out0), 32'h0);
        chk("rst_rise", 32'(rise0), 32'h0);
        chk("rst_chg",  32'(chg0), 32'h0);
        RST = 1'b0;

        // Polarity: ch5 pin low but active-low -> debounces to 1.
        tick(2);
        strobe(); tick(3);
        strobe(); chk("pol_out5_s2", 32'(out0[5]), 32'h0); tick(3);
        strobe();
        chk("pol_out5", 32'(out0[5]), 32'h1);
        chk("pol_rise5", 32'(rise0[5]), 32'h1);
        chk("pol_chg", 32'(chg0), 32'h1);
        tick(1);
        chk("pol_rise5_width", 32'(rise0[5]), 32'h0);
        tick(2);
        IN[5] = 1'b1;
        tick(2);
        strobe(); tick(3);
        strobe(); chk("pol_hold5", 32'(out0[5]), 32'h1); tick(3);
        strobe();
        chk("pol_out5_fall", 32'(out0[5]), 32'h0);
        chk("pol_fall5", 32'(fall0[5]), 32'h1);
        tick(1);
        chk("pol_fall5_width", 32'(fall0[5]), 32'h0);
        tick(2);

        // Basic debounce on ch2.
        IN[2] = 1'b1;
        tick(2);
        strobe(); chk("basic_s1", 32'(out0[2]), 32'h0); tick(3);
        strobe(); chk("basic_s2", 32'(out0[2]), 32'h0); tick(3);
        strobe();
        chk("basic_out2", 32'(out0[2]), 32'h1);
        chk("basic_rise2", 32'(rise0), 32'h04);
        chk("basic_chg", 32'(chg0), 32'h1);
        tick(1);
        chk("basic_rise2_clr", 32'(rise0[2]), 32'h0);
        chk("basic_chg_clr", 32'(chg0), 32'h0);
        tick(2);

        // Glitch rejection on ch1.
        f0 = fall1_cnt;
        IN[1] = 1'b1;
        tick(2);
        strobe(); tick(3);
        strobe(); tick(3);
        IN[1] = 1'b0;
        tick(2);
        strobe(); tick(3);
        IN[1] = 1'b1;
        tick(2);
        strobe(); tick(3);
        strobe(); chk("glitch_hold1", 32'(out0[1]), 32'h0); tick(3);
        strobe(); chk("glitch_out1", 32'(out0[1]), 32'h1);
        tick(3);
        chk("glitch_no_fall1", 32'(fall1_cnt - f0), 32'h0);

        // Reset mid-count on ch0.
        IN[0] = 1'b1;
        tick(2);
        strobe(); tick(3);
        strobe(); tick(1);
        RST = 1'b1;
        #1;
        chk("rstmid_out", 32'(out0), 32'h0);
        chk("rstmid_rise", 32'(rise0), 32'h0);
        tick(1);
        RST = 1'b0;
        tick(2);
        strobe(); tick(3);
        strobe(); chk("rstmid_hold0", 32'(out0[0]), 32'h0); tick(3);
        strobe(); chk("rstmid_out0", 32'(out0[0]), 32'h1);
        tick(2);

        // Continuous strobe, DEB_CNT=1 instance, ch7 toggling every 5 CLKs.
        SMP_EN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nv = (k % 2 == 0);
            IN[7] = nv;
            tick(2);
            chk("cont_pre7", 32'(out1[7]), 32'(!nv));
            tick(1);
            chk("cont_out7", 32'(out1[7]), 32'(nv));
            chk("cont_edge7", 32'(nv ? rise1[7] : fall1[7]), 32'h1);
            tick(1);
            chk("cont_width7", 32'(rise1[7] | fall1[7]), 32'h0);
            tick(1);
        end

`ifdef IDEB_STICKY_EN
        // Set and clear on the same edge: set wins; then clear alone.
        IN[3] = 1'b1;
        tick(3);
        chk("stk_rise3", 32'(rise1[3]), 32'h1);
        STK_CLR = 8'h08;
        tick(1);
        chk("stk_setwins3", 32'(sticky1[3]), 32'h1);
        tick(1);
        chk("stk_clr3", 32'(sticky1[3]), 32'h0);
        chk("stk_other7", 32'(sticky1[7]), 32'h1);
        STK_CLR = '0;
        tick(2);
`endif
        SMP_EN = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            SMP_EN = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 11) == 0) IN[c] = ~IN[c];
            end
            if ($urandom_range(0, 299) == 0) POL[$urandom_range(0, NCH-1)] ^= 1'b1;
`ifdef IDEB_STICKY_EN
            STK_CLR = NCH'($urandom) & NCH'($urandom);
`endif
            if ($urandom_range(0, 799) == 0) begin
                RST = 1'b1;
                tick(1);
                RST = 1'b0;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
